array_arbiter: RTL and testbench
================================

ARRAY_ARBITER -- requirements
Module: array_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one array lookup port (2..8).
REQ-002 Parameter ADDR_WIDTH, default 2: array address width.
REQ-003 Parameter DATA_WIDTH, default 16: fixed-point array data word width; the exponent is carried unchanged by the surrounding real-number macros, not by this block.
REQ-004 Parameter READ_LATENCY, default 1: cycles from arr_addr sample to valid arr_data (1..4).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 req_valid  input  N_REQ  per-requester lookup request.
REQ-008 req_addr  input  N_REQ*ADDR_WIDTH  per-requester address; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 req_ready  output  N_REQ  one-hot grant; a request transfers when req_valid[i] and req_ready[i] are both high.
REQ-010 arr_addr  output  ADDR_WIDTH  registered address to the array instance.
REQ-011 arr_data  input  DATA_WIDTH  array read data, READ_LATENCY cycles after arr_addr.
REQ-012 rsp_valid  output  N_REQ  one-hot, one-cycle response strobe to the originating requester.
REQ-013 rsp_data  output  DATA_WIDTH  shared response data, valid when any rsp_valid bit is high.

Function
REQ-014 Round-robin arbitration; at most one grant per cycle; highest priority is the requester after the last granted one, wrapping from N_REQ-1 to 0.
REQ-015 req_ready is combinational from req_valid and the priority pointer; req_ready[i] is never high while req_valid[i] is low.
REQ-016 The priority pointer advances only on a transfer; no requests leaves it unchanged.
REQ-017 On a transfer, arr_addr is loaded with the granted address on the same edge; with no transfer arr_addr holds its value.
REQ-018 A tag pipeline of depth READ_LATENCY carries {valid, grant index}; rsp_valid[idx] pulses exactly READ_LATENCY cycles after the arr_addr update, with rsp_data = arr_data in that cycle (combinational pass-through).
REQ-019 Full throughput: back-to-back transfers every cycle are accepted; responses have no backpressure and are never dropped outside reset.
REQ-020 Simultaneous requests from all N_REQ requesters each receive exactly one grant within N_REQ consecutive cycles.
REQ-021 A requester may change req_addr only after its transfer; the address is captured at the transfer edge only.
REQ-022 With no response in flight, rsp_valid is all zero and rsp_data is don't-care (must not be X-checked).

Reset
REQ-023 Reset drives arr_addr to 0, rsp_valid to 0, tag pipeline valids to 0, and the priority pointer so requester 0 has highest priority.
REQ-024 Reset asserted mid-operation discards all in-flight responses; no rsp_valid pulse follows for requests accepted before reset.
REQ-025 req_ready is all zero while rst is high.

Configuration
REQ-026 Macro ARRAY_ARBITER_STATS_EN: when defined, output grant_count (N_REQ*16 bits) holds per-requester 16-bit saturating transfer counters, reset to 0, incremented on each transfer, held at 16'hFFFF; when undefined the port and counters are absent and behaviour is otherwise identical.

Structure
REQ-027 Package array_arbiter_pkg holds the default N_REQ, the max READ_LATENCY constant, and the tag struct type {valid, index}.
REQ-028 Round-robin grant logic is a sub-module rr_arbiter (req, pointer in; one-hot grant, index out); pipeline and address register stay in array_arbiter.

Verification
REQ-029 Single requester: req_valid[2]=1, addr=3, arr_data model = 10.0 fixed-point at index 3 -> req_ready[2] same cycle, arr_addr=3 next edge, rsp_valid=4'b0100 with rsp_data=10.0 one cycle later (READ_LATENCY=1).
REQ-030 All four requesting continuously after reset -> grants in order 0,1,2,3,0,...; one transfer per cycle; responses in same order.
REQ-031 Requesters 1 and 3 only, pointer after 3 -> grants alternate 1,3,1,3; no idle cycles.
REQ-032 READ_LATENCY=3, three back-to-back transfers then reset asserted asynchronously mid-cycle -> no rsp_valid pulses after reset; arr_addr=0; first grant after release goes to requester 0.
REQ-033 No requests for 10 cycles -> arr_addr holds last value, pointer unchanged, rsp_valid stays 0.
REQ-034 With ARRAY_ARBITER_STATS_EN, requester 0 granted 70000 times -> grant_count[0] saturates at 16'hFFFF; others unchanged.

Source files
------------

// File: rtl/array_arbiter_pkg.sv
// array_arbiter_pkg: shared constants, tag type and helpers for array_arbiter.
//   DEFAULT_N_REQ     default number of requesters
//   MAX_N_REQ         largest supported requester count (sizes index fields)
//   MAX_READ_LATENCY  largest supported array read latency
//   IDX_W             width of a requester index
//   CNT_W             width of one per-requester transfer counter (stats build)
//   tag_t             response tag {valid, index} carried alongside the array read
//   next_ptr()        round-robin pointer successor with wrap
package array_arbiter_pkg;

  localparam int unsigned DEFAULT_N_REQ    = 4;
  localparam int unsigned MAX_N_REQ        = 8;
  localparam int unsigned MAX_READ_LATENCY = 4;
  localparam int unsigned IDX_W            = $clog2(MAX_N_REQ);
  localparam int unsigned CNT_W            = 16;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] index;
  } tag_t;

  // Requester that gets top priority after idx was granted, wrapping n-1 -> 0.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx,
                                                 input int unsigned      n);
    logic [IDX_W-1:0] nxt;
    if (idx == IDX_W'(n - 1)) begin
      nxt = '0;
    end else begin
      nxt = IDX_W'(idx + IDX_W'(1));
    end
    return nxt;
  endfunction

endpackage

// File: rtl/array_arbiter_rr.sv
// rr_arbiter: combinational round-robin grant selection.
//   req          per-requester request vector
//   ptr          index of the requester holding top priority this cycle
//   grant_c      one-hot grant (zero when no request)
//   grant_idx_c  binary index of the granted requester
//   grant_any_c  high when some requester is granted
module rr_arbiter
  import array_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = DEFAULT_N_REQ
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant_c,
  output logic [IDX_W-1:0] grant_idx_c,
  output logic             grant_any_c
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] cand_sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk requesters in priority order ptr, ptr+1, ... (mod N_REQ); first hit wins.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    found       = 1'b0;
    cand_sum    = '0;
    cand        = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand_sum = SUM_W'(ptr) + SUM_W'(k);
      if (cand_sum >= SUM_W'(N_REQ)) begin
        cand_sum = cand_sum - SUM_W'(N_REQ);
      end
      cand = IDX_W'(cand_sum);
      // Compare against each constant index rather than indexing req with cand,
      // which keeps the select width-exact for any N_REQ.
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!found && req[i] && (cand == IDX_W'(i))) begin
          grant_c[i]  = 1'b1;
          grant_idx_c = IDX_W'(i);
          found       = 1'b1;
        end
      end
    end
    grant_any_c = found;
  end

endmodule

// File: rtl/array_arbiter.sv
// array_arbiter: shares one fixed-point array lookup port among N_REQ requesters.
//   clk, rst      clock; asynchronous active-high reset
//   req_valid     per-requester lookup request
//   req_addr      per-requester address, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_ready     one-hot grant, combinational from req_valid and the priority pointer
//   arr_addr      registered address to the array instance
//   arr_data      array read data, READ_LATENCY cycles after arr_addr
//   rsp_valid     one-hot, one-cycle response strobe to the originating requester
//   rsp_data      shared response data (pass-through of arr_data)
//   grant_count   per-requester 16-bit saturating transfer counters, present only
//                 when ARRAY_ARBITER_STATS_EN is defined
module array_arbiter
  import array_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ        = DEFAULT_N_REQ,
  parameter int unsigned ADDR_WIDTH   = 2,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0]  req_addr,
  output logic [N_REQ-1:0]             req_ready,
  output logic [ADDR_WIDTH-1:0]        arr_addr,
  input  logic [DATA_WIDTH-1:0]        arr_data,
  output logic [N_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_data
`ifdef ARRAY_ARBITER_STATS_EN
  ,
  output logic [N_REQ*CNT_W-1:0]       grant_count
`endif
);

  // Out-of-range latencies are clamped into the supported 1..MAX range.
  localparam int unsigned LAT = (READ_LATENCY < 1) ? 1 :
                                ((READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY
                                                                   : READ_LATENCY);

  logic [N_REQ-1:0]      grant_c;
  logic [IDX_W-1:0]      grant_idx_c;
  logic                  grant_any_c;
  logic                  xfer_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;

  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] arr_addr_q, arr_addr_d;
  tag_t                  tag_q [LAT];
  tag_t                  tag_d [LAT];
  logic [N_REQ-1:0]      rsp_valid_q, rsp_valid_d;

  // Round-robin selection among active requests.
  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_rr (
    .req        (req_valid),
    .ptr        (ptr_q),
    .grant_c    (grant_c),
    .grant_idx_c(grant_idx_c),
    .grant_any_c(grant_any_c)
  );

  // No grant is offered while reset is held.
  assign req_ready = rst ? '0 : grant_c;
  assign xfer_c    = grant_any_c & ~rst;

  // Address of the granted requester.
  always_comb begin
    sel_addr_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_c[i]) begin
        sel_addr_c = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Next state: pointer and address move only on a transfer. tag stage 0 is
  // aligned with arr_addr; the final one-hot register adds the array's own
  // cycle, so rsp_valid lands READ_LATENCY cycles after arr_addr changes.
  always_comb begin
    ptr_d       = ptr_q;
    arr_addr_d  = arr_addr_q;
    rsp_valid_d = '0;
    for (int unsigned s = 0; s < LAT; s++) begin
      tag_d[s] = '0;
    end

    if (xfer_c) begin
      ptr_d      = next_ptr(grant_idx_c, N_REQ);
      arr_addr_d = sel_addr_c;
    end

    tag_d[0].valid = xfer_c;
    tag_d[0].index = xfer_c ? grant_idx_c : '0;
    for (int unsigned s = 1; s < LAT; s++) begin
      tag_d[s] = tag_q[s-1];
    end

    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (tag_q[LAT-1].valid && (tag_q[LAT-1].index == IDX_W'(i))) begin
        rsp_valid_d[i] = 1'b1;
      end
    end
  end

  // State registers; reset drops every in-flight tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      arr_addr_q  <= '0;
      rsp_valid_q <= '0;
      for (int unsigned s = 0; s < LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      arr_addr_q  <= arr_addr_d;
      rsp_valid_q <= rsp_valid_d;
      for (int unsigned s = 0; s < LAT; s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

  assign arr_addr  = arr_addr_q;
  assign rsp_valid = rsp_valid_q;
  // Array data flows straight through in the strobe cycle.
  assign rsp_data  = arr_data;

`ifdef ARRAY_ARBITER_STATS_EN
  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [CNT_W-1:0] cnt_d [N_REQ];

  // Saturating per-requester transfer counters.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (xfer_c && grant_c[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    grant_count = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      grant_count[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_array_arbiter.sv
// tb_array_arbiter: directed self-checking bench for array_arbiter.
// dut uses READ_LATENCY=1, dut3 uses READ_LATENCY=3; both share request inputs
// and each has its own reset and array model. Array words are Q8.8 fixed point.
module tb_array_arbiter;

  logic        clk;
  logic        rst;
  logic        rst3;
  logic [3:0]  req_valid;
  logic [7:0]  req_addr;
  logic [3:0]  req_ready, req_ready3;
  logic [1:0]  arr_addr, arr_addr3;
  logic [15:0] arr_data, arr_data3;
  logic [3:0]  rsp_valid, rsp_valid3;
  logic [15:0] rsp_data, rsp_data3;
  logic [15:0] d3_p1, d3_p2;
  logic [15:0] mem [4];
`ifdef ARRAY_ARBITER_STATS_EN
  logic [63:0] grant_count, grant_count3;
`endif

  int checks;
  int failures;

  array_arbiter #(
    .N_REQ(4), .ADDR_WIDTH(2), .DATA_WIDTH(16), .READ_LATENCY(1)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .arr_addr(arr_addr), .arr_data(arr_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
`ifdef ARRAY_ARBITER_STATS_EN
    , .grant_count(grant_count)
`endif
  );

  array_arbiter #(
    .N_REQ(4), .ADDR_WIDTH(2), .DATA_WIDTH(16), .READ_LATENCY(3)
  ) dut3 (
    .clk(clk), .rst(rst3), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready3), .arr_addr(arr_addr3), .arr_data(arr_data3),
    .rsp_valid(rsp_valid3), .rsp_data(rsp_data3)
`ifdef ARRAY_ARBITER_STATS_EN
    , .grant_count(grant_count3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array models: 1-cycle and 3-cycle registered reads.
  always @(posedge clk) begin
    arr_data  <= mem[arr_addr];
    d3_p1     <= mem[arr_addr3];
    d3_p2     <= d3_p1;
    arr_data3 <= d3_p2;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit reached, expected $finish earlier");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rst3 = 1'b1; req_valid = 4'hF; req_addr = '0;
    repeat (2) step();
    sample();
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++; $display("FAIL reset_ready: got %b expected %b", req_ready, 4'b0000);
    end
    checks++;
    if (arr_addr !== 2'd0) begin
      failures++; $display("FAIL reset_arr_addr: got %0d expected 0", arr_addr);
    end
    checks++;
    if (rsp_valid !== 4'b0000) begin
      failures++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid);
    end
    step();
    rst = 1'b0; req_valid = 4'h0;
  endtask

  // Requester 2 alone, address 3 holds 10.0.
  task automatic test_single();
    req_addr = 8'h30; req_valid = 4'b0100;
    sample();
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++; $display("FAIL single_ready: got %b expected 0100", req_ready);
    end
    step();
    req_valid = 4'h0;
    checks++;
    if (arr_addr !== 2'd3) begin
      failures++; $display("FAIL single_arr_addr: got %0d expected 3", arr_addr);
    end
    sample();
    checks++;
    if (rsp_valid !== 4'b0000) begin
      failures++; $display("FAIL single_rsp_early: got %b expected 0000", rsp_valid);
    end
    step(); sample();
    checks++;
    if (rsp_valid !== 4'b0100) begin
      failures++; $display("FAIL single_rsp_valid: got %b expected 0100", rsp_valid);
    end
    checks++;
    if (rsp_data !== 16'h0A00) begin
      failures++; $display("FAIL single_rsp_data: got %h expected 0a00", rsp_data);
    end
    step(); sample();
    checks++;
    if (rsp_valid !== 4'b0000) begin
      failures++; $display("FAIL single_rsp_pulse: got %b expected 0000", rsp_valid);
    end
    step();
  endtask

  // All four requesting after reset: grants 0,1,2,3,0,1,2,3 and matching responses.
  task automatic test_round_robin();
    logic [3:0] exp_v;
    logic [1:0] exp_a;
    rst = 1'b1; step(); rst = 1'b0;
    req_addr = 8'hE4;
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      sample();
      if (c < 8) begin
        exp_v = 4'b0001 << (c % 4);
        checks++;
        if (req_ready !== exp_v) begin
          failures++; $display("FAIL rr_grant c=%0d: got %b expected %b", c, req_ready, exp_v);
        end
      end
      if (c >= 1 && c <= 8) begin
        exp_a = 2'((c - 1) % 4);
        checks++;
        if (arr_addr !== exp_a) begin
          failures++; $display("FAIL rr_arr_addr c=%0d: got %0d expected %0d", c, arr_addr, exp_a);
        end
      end
      if (c >= 2) begin
        exp_v = 4'b0001 << ((c - 2) % 4);
        checks++;
        if (rsp_valid !== exp_v) begin
          failures++; $display("FAIL rr_rsp_valid c=%0d: got %b expected %b", c, rsp_valid, exp_v);
        end
        checks++;
        if (rsp_data !== mem[(c - 2) % 4]) begin
          failures++; $display("FAIL rr_rsp_data c=%0d: got %h expected %h", c, rsp_data, mem[(c - 2) % 4]);
        end
      end
      step();
    end
  endtask

  // Requesters 1 (addr 1) and 3 (addr 2) with pointer past 3: alternate 1,3,1,3.
  task automatic test_alternate();
    logic [3:0]  exp_v;
    logic [15:0] exp_d;
    req_addr = 8'h84;
    for (int c = 0; c < 6; c++) begin
      req_valid = (c < 4) ? 4'b1010 : 4'h0;
      sample();
      if (c < 4) begin
        exp_v = (c % 2 == 0) ? 4'b0010 : 4'b1000;
        checks++;
        if (req_ready !== exp_v) begin
          failures++; $display("FAIL alt_grant c=%0d: got %b expected %b", c, req_ready, exp_v);
        end
      end
      if (c >= 2) begin
        exp_v = (c % 2 == 0) ? 4'b0010 : 4'b1000;
        exp_d = (c % 2 == 0) ? mem[1] : mem[2];
        checks++;
        if (rsp_valid !== exp_v) begin
          failures++; $display("FAIL alt_rsp_valid c=%0d: got %b expected %b", c, rsp_valid, exp_v);
        end
        checks++;
        if (rsp_data !== exp_d) begin
          failures++; $display("FAIL alt_rsp_data c=%0d: got %h expected %h", c, rsp_data, exp_d);
        end
      end
      step();
    end
  endtask

  // One transfer from requester 1 (pointer -> 2), then 10 idle cycles.
  task automatic test_idle();
    req_addr = 8'h04; req_valid = 4'b0010;
    sample();
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++; $display("FAIL idle_setup_grant: got %b expected 0010", req_ready);
    end
    step();
    req_valid = 4'h0;
    repeat (2) step();
    for (int c = 0; c < 10; c++) begin
      sample();
      checks++;
      if (rsp_valid !== 4'b0000) begin
        failures++; $display("FAIL idle_rsp_valid c=%0d: got %b expected 0000", c, rsp_valid);
      end
      checks++;
      if (arr_addr !== 2'd1) begin
        failures++; $display("FAIL idle_arr_addr c=%0d: got %0d expected 1", c, arr_addr);
      end
      checks++;
      if (req_ready !== 4'b0000) begin
        failures++; $display("FAIL idle_ready c=%0d: got %b expected 0000", c, req_ready);
      end
      step();
    end
    req_valid = 4'hF; req_addr = 8'hE4;
    sample();
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++; $display("FAIL idle_pointer_held: got %b expected 0100", req_ready);
    end
    step();
    req_valid = 4'h0;
    repeat (3) step();
  endtask

  // READ_LATENCY=3: three transfers, async reset mid-cycle, no stale responses.
  task automatic test_reset_midflight();
    logic [3:0] exp_v;
    req_addr = 8'hE4; req_valid = 4'h0; rst3 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'b0111;
      sample();
      exp_v = 4'b0001 << c;
      checks++;
      if (req_ready3 !== exp_v) begin
        failures++; $display("FAIL mid_grant c=%0d: got %b expected %b", c, req_ready3, exp_v);
      end
      checks++;
      if (rsp_valid3 !== 4'b0000) begin
        failures++; $display("FAIL mid_rsp_early c=%0d: got %b expected 0000", c, rsp_valid3);
      end
      step();
    end
    req_valid = 4'h0;
    checks++;
    if (arr_addr3 !== 2'd2) begin
      failures++; $display("FAIL mid_arr_addr_pre: got %0d expected 2", arr_addr3);
    end
    #2;
    rst3 = 1'b1;
    #1;
    req_valid = 4'hF;
    #1;
    checks++;
    if (arr_addr3 !== 2'd0) begin
      failures++; $display("FAIL mid_arr_addr_reset: got %0d expected 0", arr_addr3);
    end
    checks++;
    if (req_ready3 !== 4'b0000) begin
      failures++; $display("FAIL mid_ready_in_reset: got %b expected 0000", req_ready3);
    end
    for (int k = 0; k < 6; k++) begin
      sample();
      checks++;
      if (rsp_valid3 !== 4'b0000) begin
        failures++; $display("FAIL mid_rsp_after_reset k=%0d: got %b expected 0000", k, rsp_valid3);
      end
      step();
    end
    rst3 = 1'b0;
    sample();
    checks++;
    if (req_ready3 !== 4'b0001) begin
      failures++; $display("FAIL mid_first_grant: got %b expected 0001", req_ready3);
    end
    step();
    req_valid = 4'h0;
    for (int k = 1; k <= 6; k++) begin
      sample();
      exp_v = (k == 4) ? 4'b0001 : 4'b0000;
      checks++;
      if (rsp_valid3 !== exp_v) begin
        failures++; $display("FAIL mid_lat3_rsp k=%0d: got %b expected %b", k, rsp_valid3, exp_v);
      end
      if (k == 4) begin
        checks++;
        if (rsp_data3 !== mem[0]) begin
          failures++; $display("FAIL mid_lat3_data: got %h expected %h", rsp_data3, mem[0]);
        end
      end
      step();
    end
  endtask

`ifdef ARRAY_ARBITER_STATS_EN
  // Requester 0 granted 70000 times: its counter saturates, others stay 0.
  task automatic test_stats();
    rst = 1'b1; req_valid = 4'h0; step();
    rst = 1'b0; req_valid = 4'b0001;
    repeat (5) step();
    sample();
    checks++;
    if (grant_count[15:0] !== 16'd5) begin
      failures++; $display("FAIL stats_count5: got %0d expected 5", grant_count[15:0]);
    end
    step();
    repeat (70000 - 6) step();
    sample();
    checks++;
    if (grant_count[15:0] !== 16'hFFFF) begin
      failures++; $display("FAIL stats_saturate: got %h expected ffff", grant_count[15:0]);
    end
    checks++;
    if (grant_count[63:16] !== 48'd0) begin
      failures++; $display("FAIL stats_others: got %h expected 0", grant_count[63:16]);
    end
    step();
    req_valid = 4'h0;
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    mem[0] = 16'h0100;  // 1.0
    mem[1] = 16'h0280;  // 2.5
    mem[2] = 16'h0540;  // 5.25
    mem[3] = 16'h0A00;  // 10.0
    test_reset();
    test_single();
    test_round_robin();
    test_alternate();
    test_idle();
    test_reset_midflight();
`ifdef ARRAY_ARBITER_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
